// File: rtl/matmul_pkg.sv
//------------------------------------------------------------------------------
// Module  : matmul_pkg
// Purpose : Shared types and constants for the matrix-multiply sequencer:
//           data/address widths, default acknowledge timeout and the FSM
//           state enumeration (each transfer phase split into ISSUE/WAIT).
// Ports   : none (package)
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package matmul_pkg;

  localparam int DATA_W          = 256;
  localparam int ADDR_W          = 16;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RDA_ISS  = 4'd1,
    S_RDA_WAIT = 4'd2,
    S_LDA_ISS  = 4'd3,
    S_LDA_WAIT = 4'd4,
    S_RDB_ISS  = 4'd5,
    S_RDB_WAIT = 4'd6,
    S_LDB_ISS  = 4'd7,
    S_LDB_WAIT = 4'd8,
    S_RDC_ISS  = 4'd9,
    S_RDC_WAIT = 4'd10,
    S_WRC_ISS  = 4'd11,
    S_WRC_WAIT = 4'd12,
    S_DONE     = 4'd13,
    S_ERR      = 4'd14
  } state_e;

endpackage

`default_nettype wire

// File: rtl/matmul_watchdog.sv
//------------------------------------------------------------------------------
// Module  : matmul_watchdog
// Purpose : Acknowledge watchdog. Cleared on every ISSUE cycle, counts WAIT
//           cycles; expired_o flags the TIMEOUT-th consecutive WAIT cycle so
//           the sequencer can abort at the end of it.
// Ports   : clk, nReset (sync, active-low), clear_i, count_i -> expired_o
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module matmul_watchdog
  import matmul_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic nReset,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  // The counter holds "WAIT cycles already elapsed", so it only has to reach
  // TIMEOUT-1.
  localparam int                 CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired_o = count_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_i && !expired_o) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/matrix_mult_sequencer.sv
//------------------------------------------------------------------------------
// Module  : matrix_mult_sequencer
// Purpose : Sequences one matrix-multiply job: read A from memory, load it
//           into the engine, same for B, read the product C back from the
//           engine and write it to memory. One 256-bit buffer carries data
//           between the two sides. Each phase issues one strobe cycle and then
//           waits for its acknowledge, guarded by a watchdog.
// Ports   : clk, nReset (sync, active-low), start, srcAddrA/B, dstAddr
//           busy, done, error (status)
//           memEnable/memRW/memAddr/memDataOut/memDataIn/memFleg (memory)
//           multEnable/multRW/multMatDecide/multDataOut/multDataIn/multFleg
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module matrix_mult_sequencer
  import matmul_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcAddrA,
  input  logic [ADDR_W-1:0] srcAddrB,
  input  logic [ADDR_W-1:0] dstAddr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              memEnable,
  output logic              memRW,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataOut,
  input  logic [DATA_W-1:0] memDataIn,
  input  logic              memFleg,
  output logic              multEnable,
  output logic              multRW,
  output logic              multMatDecide,
  output logic [DATA_W-1:0] multDataOut,
  input  logic [DATA_W-1:0] multDataIn,
  input  logic              multFleg
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;

  logic              mem_en, mem_rw, mult_en, mult_rw, mult_sel, done_s, error_s;
  logic [ADDR_W-1:0] mem_addr;
  logic              wd_clear, wd_count, wd_expired;

  matmul_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .nReset   (nReset),
    .clear_i  (wd_clear),
    .count_i  (wd_count),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    addr_c_d = addr_c_q;
    mem_en   = 1'b0;
    mem_rw   = 1'b0;
    mem_addr = '0;
    mult_en  = 1'b0;
    mult_rw  = 1'b0;
    mult_sel = 1'b0;
    done_s   = 1'b0;
    error_s  = 1'b0;
    wd_clear = 1'b0;
    wd_count = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_a_d = srcAddrA;
          addr_b_d = srcAddrB;
          addr_c_d = dstAddr;
          state_d  = S_RDA_ISS;
        end
      end
      S_RDA_ISS: begin
        mem_en   = 1'b1;
        mem_addr = addr_a_q;
        wd_clear = 1'b1;
        state_d  = S_RDA_WAIT;
      end
      S_RDA_WAIT: begin
        wd_count = 1'b1;
        if (memFleg) begin
          buf_d   = memDataIn;
          state_d = S_LDA_ISS;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_LDA_ISS: begin
        mult_en  = 1'b1;
        mult_rw  = 1'b1;
        wd_clear = 1'b1;
        state_d  = S_LDA_WAIT;
      end
      S_LDA_WAIT: begin
        wd_count = 1'b1;
        if (multFleg) begin
          state_d = S_RDB_ISS;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_RDB_ISS: begin
        mem_en   = 1'b1;
        mem_addr = addr_b_q;
        wd_clear = 1'b1;
        state_d  = S_RDB_WAIT;
      end
      S_RDB_WAIT: begin
        wd_count = 1'b1;
        if (memFleg) begin
          buf_d   = memDataIn;
          state_d = S_LDB_ISS;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_LDB_ISS: begin
        mult_en  = 1'b1;
        mult_rw  = 1'b1;
        mult_sel = 1'b1;
        wd_clear = 1'b1;
        state_d  = S_LDB_WAIT;
      end
      S_LDB_WAIT: begin
        wd_count = 1'b1;
        if (multFleg) begin
          state_d = S_RDC_ISS;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_RDC_ISS: begin
        mult_en  = 1'b1;
        wd_clear = 1'b1;
        state_d  = S_RDC_WAIT;
      end
      S_RDC_WAIT: begin
        wd_count = 1'b1;
        if (multFleg) begin
          buf_d   = multDataIn;
          state_d = S_WRC_ISS;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_WRC_ISS: begin
        mem_en   = 1'b1;
        mem_rw   = 1'b1;
        mem_addr = addr_c_q;
        wd_clear = 1'b1;
        state_d  = S_WRC_WAIT;
      end
      S_WRC_WAIT: begin
        wd_count = 1'b1;
        if (memFleg) begin
          state_d = S_DONE;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        done_s  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        error_s = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      buf_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_c_q <= addr_c_d;
    end
  end

  // Outputs are forced low while reset is held, so nothing leaks out of an
  // abandoned job before the reset edge arrives.
  assign busy          = nReset && (state_q != S_IDLE);
  assign done          = nReset && done_s;
  assign error         = nReset && error_s;
  assign memEnable     = nReset && mem_en;
  assign memRW         = nReset && mem_rw;
  assign memAddr       = nReset ? mem_addr : '0;
  assign memDataOut    = nReset ? buf_q : '0;
  assign multEnable    = nReset && mult_en;
  assign multRW        = nReset && mult_rw;
  assign multMatDecide = nReset && mult_sel;
  assign multDataOut   = nReset ? buf_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_matrix_mult_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_matrix_mult_sequencer
// Purpose : Self-checking bench for matrix_mult_sequencer. A memory model and
//           a 4x4x16-bit matrix engine model answer the DUT strobes with
//           configurable acknowledge latency; results are compared against
//           expectations derived from the job definition.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_matrix_mult_sequencer;

  logic         clk = 1'b0;
  logic         nReset, start;
  logic [15:0]  srcAddrA, srcAddrB, dstAddr;
  logic         busy, done, error;
  logic         memEnable, memRW, memFleg;
  logic [15:0]  memAddr;
  logic [255:0] memDataOut, memDataIn;
  logic         multEnable, multRW, multMatDecide, multFleg;
  logic [255:0] multDataOut, multDataIn;

  matrix_mult_sequencer dut (
    .clk(clk), .nReset(nReset), .start(start),
    .srcAddrA(srcAddrA), .srcAddrB(srcAddrB), .dstAddr(dstAddr),
    .busy(busy), .done(done), .error(error),
    .memEnable(memEnable), .memRW(memRW), .memAddr(memAddr),
    .memDataOut(memDataOut), .memDataIn(memDataIn), .memFleg(memFleg),
    .multEnable(multEnable), .multRW(multRW), .multMatDecide(multMatDecide),
    .multDataOut(multDataOut), .multDataIn(multDataIn), .multFleg(multFleg)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] ident(input logic [15:0] s);
    logic [255:0] v = '0;
    for (int i = 0; i < 4; i++) v[(i*4+i)*16 +: 16] = s;
    return v;
  endfunction

  // 4x4 matrix of 16-bit elements, row-major, arithmetic modulo 2^16.
  function automatic logic [255:0] ref_mult(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r = '0;
    logic [15:0]  s, ae, be;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = '0;
        for (int k = 0; k < 4; k++) begin
          ae = a[(i*4+k)*16 +: 16];
          be = b[(k*4+j)*16 +: 16];
          s  = s + ae * be;
        end
        r[(i*4+j)*16 +: 16] = s;
      end
    return r;
  endfunction

  // Strobe codes in expected order: RD_A=0 LD_A=1 RD_B=2 LD_B=3 RD_C=4 WR_C=5
  function automatic int exp_enc(input int n);
    int e = 0;
    for (int i = 0; i < n; i++) e = e * 8 + i;
    return e;
  endfunction

  // Job configuration
  int cfg_mem_lat, cfg_mult_lat, cfg_rst_cycle, cfg_spur_start, cfg_spur_mult;
  bit cfg_hang_ldb, cfg_start_in_done;

  // Job observations
  int           done_cycle, err_cycle, done_count, err_count, end_cycle;
  int           busy_low, idle_bad, zero_bad, wr_count;
  bit           finished;
  int           seq[$];
  logic [255:0] engA, engB, wr_data;
  logic [15:0]  wr_addr;
  logic [255:0] mem [logic [15:0]];

  function automatic int seq_enc();
    int e = 0;
    foreach (seq[i]) e = e * 8 + seq[i];
    return e;
  endfunction

  task automatic cfg_default();
    cfg_mem_lat = 1; cfg_mult_lat = 1; cfg_rst_cycle = 0;
    cfg_spur_start = 0; cfg_spur_mult = 0;
    cfg_hang_ldb = 0; cfg_start_in_done = 0;
  endtask

  task automatic run_job(input logic [255:0] a, input logic [255:0] b,
                         input logic [15:0] aa, input logic [15:0] ab,
                         input logic [15:0] ac, input int max_cycles);
    int mem_ack_at = -1, mult_ack_at = -1;
    logic [255:0] rd_data = '0, eng_data = '0;
    logic any_out;
    mem.delete();
    mem[aa] = a; mem[ab] = b;
    done_cycle = -1; err_cycle = -1; done_count = 0; err_count = 0; end_cycle = -1;
    busy_low = 0; idle_bad = 0; zero_bad = 0; wr_count = 0; finished = 0;
    seq.delete();
    engA = 'x; engB = 'x; wr_data = 'x; wr_addr = 'x;
    srcAddrA = aa; srcAddrB = ab; dstAddr = ac;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= max_cycles; n++) begin
      any_out = busy | done | error | memEnable | memRW | (|memAddr) | (|memDataOut) |
                multEnable | multRW | multMatDecide | (|multDataOut);
      if (done)  begin done_count++; done_cycle = n; end
      if (error) begin err_count++;  err_cycle  = n; end
      if (end_cycle < 0 && !busy && cfg_rst_cycle == 0) busy_low++;
      if (end_cycle >= 0 && busy) idle_bad++;
      if (cfg_rst_cycle > 0 && n > cfg_rst_cycle && any_out) zero_bad++;
      if (end_cycle < 0 && (done || error)) end_cycle = n;

      if (memEnable) begin
        if (memRW) begin
          seq.push_back(5);
          wr_count++; wr_addr = memAddr; wr_data = memDataOut;
          mem[memAddr] = memDataOut;
        end else begin
          seq.push_back(memAddr == aa ? 0 : (memAddr == ab ? 2 : 7));
          rd_data = mem.exists(memAddr) ? mem[memAddr] : '0;
        end
        mem_ack_at = n + cfg_mem_lat;
      end
      if (multEnable) begin
        if (multRW) begin
          if (multMatDecide) begin seq.push_back(3); engB = multDataOut; end
          else               begin seq.push_back(1); engA = multDataOut; end
        end else begin
          seq.push_back(4);
          eng_data = ref_mult(engA, engB);
        end
        if (!(cfg_hang_ldb && multRW && multMatDecide)) mult_ack_at = n + cfg_mult_lat;
      end
      if (n == cfg_rst_cycle) begin mem_ack_at = -1; mult_ack_at = -1; end

      memFleg    = (n == mem_ack_at);
      memDataIn  = memFleg ? rd_data : rnd256();
      multFleg   = (n == mult_ack_at) || (n == cfg_spur_mult);
      multDataIn = (n == mult_ack_at) ? eng_data : rnd256();
      start      = (n == cfg_spur_start) || (cfg_start_in_done && done);
      nReset     = (n != cfg_rst_cycle);

      if ((end_cycle >= 0 && n >= end_cycle + 2) ||
          (cfg_rst_cycle > 0 && n >= cfg_rst_cycle + 2)) begin
        finished = 1;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; nReset = 1'b1; memFleg = 1'b0; multFleg = 1'b0;
  endtask

  task automatic check_normal(input string tag, input int exp_done,
                              input logic [255:0] a, input logic [255:0] b,
                              input logic [15:0] ac);
    check({tag, "_finished"},   finished, 1);
    check({tag, "_done_cycle"}, done_cycle, exp_done);
    check({tag, "_done_count"}, done_count, 1);
    check({tag, "_err_count"},  err_count, 0);
    check({tag, "_strobes"},    seq.size(), 6);
    check({tag, "_order"},      seq_enc(), exp_enc(6));
    check({tag, "_eng_A"},      engA, a);
    check({tag, "_eng_B"},      engB, b);
    check({tag, "_wr_count"},   wr_count, 1);
    check({tag, "_wr_addr"},    wr_addr, ac);
    check({tag, "_wr_data"},    wr_data, ref_mult(a, b));
    check({tag, "_busy"},       busy_low, 0);
    check({tag, "_idle_after"}, idle_bad, 0);
  endtask

  typedef struct {
    int mem_lat;
    int mult_lat;
    int kind;       // 0: identity x 2*identity, 1: random matrices
    int exp_done;
  } vec_t;

  initial begin
    vec_t         vecs[5];
    logic [255:0] a, b;
    logic [15:0]  aa;
    int           lm, lx;

    vecs[0] = '{mem_lat: 1,  mult_lat: 1, kind: 0, exp_done: 13};
    vecs[1] = '{mem_lat: 11, mult_lat: 1, kind: 0, exp_done: 43};
    vecs[2] = '{mem_lat: 1,  mult_lat: 5, kind: 1, exp_done: 25};
    vecs[3] = '{mem_lat: 3,  mult_lat: 2, kind: 1, exp_done: 22};
    vecs[4] = '{mem_lat: 2,  mult_lat: 3, kind: 1, exp_done: 22};

    nReset = 1'b0; start = 1'b0; memFleg = 1'b0; multFleg = 1'b0;
    memDataIn = '0; multDataIn = '0;
    srcAddrA = '0; srcAddrB = '0; dstAddr = '0;
    cfg_default();

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", busy | done | error | memEnable | memRW | (|memAddr) |
          (|memDataOut) | multEnable | multRW | multMatDecide | (|multDataOut), 0);
    nReset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", busy | memEnable | multEnable | (|memDataOut), 0);

    // Table-driven latency sweep
    for (int i = 0; i < 5; i++) begin
      cfg_default();
      cfg_mem_lat  = vecs[i].mem_lat;
      cfg_mult_lat = vecs[i].mult_lat;
      if (vecs[i].kind == 0) begin a = ident(16'd1); b = ident(16'd2); end
      else                   begin a = rnd256();     b = rnd256();     end
      run_job(a, b, 16'h1000, 16'h2000, 16'h3000, 200);
      check_normal($sformatf("vec%0d", i), vecs[i].exp_done, a, b, 16'h3000);
    end

    // Randomized jobs
    for (int i = 0; i < 6; i++) begin
      cfg_default();
      lm = $urandom_range(1, 6);
      lx = $urandom_range(1, 6);
      cfg_mem_lat = lm; cfg_mult_lat = lx;
      a  = rnd256(); b = rnd256();
      aa = 16'($urandom);
      run_job(a, b, aa, aa + 16'd1, aa + 16'd2, 200);
      check_normal($sformatf("rnd%0d", i), 7 + 3 * lm + 3 * lx, a, b, aa + 16'd2);
    end

    // Spurious start while busy (mid-job and in DONE), multFleg during RD_A
    cfg_default();
    cfg_mem_lat = 3; cfg_spur_mult = 2; cfg_spur_start = 5; cfg_start_in_done = 1;
    a = rnd256(); b = rnd256();
    run_job(a, b, 16'h0040, 16'h0080, 16'h00C0, 200);
    check_normal("spurious", 19, a, b, 16'h00C0);

    // Engine never acknowledges LD_B: watchdog abort
    cfg_default();
    cfg_hang_ldb = 1;
    run_job(ident(16'd1), ident(16'd2), 16'h0100, 16'h0200, 16'h0300, 400);
    check("timeout_finished",   finished, 1);
    check("timeout_err_cycle",  err_cycle, 263);
    check("timeout_err_count",  err_count, 1);
    check("timeout_done_count", done_count, 0);
    check("timeout_strobes",    seq.size(), 4);
    check("timeout_order",      seq_enc(), exp_enc(4));
    check("timeout_no_write",   wr_count, 0);
    check("timeout_idle_after", idle_bad, 0);

    // Reset asserted during RD_B WAIT (cycles 10..14 with memory latency 5)
    cfg_default();
    cfg_mem_lat = 5; cfg_rst_cycle = 11;
    run_job(rnd256(), rnd256(), 16'h0500, 16'h0600, 16'h0700, 100);
    check("midrst_finished",   finished, 1);
    check("midrst_zero_out",   zero_bad, 0);
    check("midrst_done_count", done_count, 0);
    check("midrst_err_count",  err_count, 0);
    check("midrst_strobes",    seq.size(), 3);
    cfg_default();
    a = ident(16'd1); b = ident(16'd2);
    run_job(a, b, 16'h0500, 16'h0600, 16'h0700, 200);
    check_normal("after_rst", 13, a, b, 16'h0700);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
